serial_subtractor_four: RTL and testbench
=========================================

# serial_subtractor_four

Bit-serial subtractor that computes Diff = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic path to the 4-bit adder in Project 1 and serves as the area-minimal subtract stage for the Project 1 datapath. Operands are captured with a start/ready handshake. The result and final borrow are presented with a one-cycle done pulse and held until the next operation completes.

## Interface
- N, default 4: operand and result width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when ready=1.
- A  input  N  minuend; captured on the accepted start.
- B  input  N  subtrahend; captured on the accepted start.
- Bin  input  1  borrow-in; captured on the accepted start.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse; Diff and Bout are valid from this cycle.
- Diff  output  N  difference, A − B − Bin mod 2^N.
- Bout  output  1  final borrow-out; 1 when A < B + Bin (unsigned).
- Ovf  output  1  signed overflow flag; present only with SUB_OVERFLOW_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: ready=1. When start=1, capture A, B and Bin into shift registers, load the borrow FF with Bin, clear the bit counter, and go to SHIFT.
  - SHIFT: ready=0. Each cycle processes bit k = counter value, from 0 to N−1.
    - d = a_k ^ b_k ^ br.
    - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br).
    - Shift d into the result register from the MSB side. Shift the A and B registers right by one.
    - After bit N−1 is processed, go to DONE.
  - DONE: done=1 and ready=1 for one cycle. Diff = result register; Bout = final borrow.
    - start=1 in DONE is accepted exactly as in IDLE and goes straight to SHIFT.
    - Otherwise go to IDLE.
- Diff, Bout and Ovf hold their last completed values through IDLE and through any following SHIFT. They update only on entry to DONE.
- start while in SHIFT is ignored. It is not queued.
- Arithmetic is unsigned modulo 2^N. Bout is the borrow out of bit N−1.
- The bit counter is ceil(log2(N)) bits wide. The terminal count is N−1; there is no wrap beyond it.

## Timing
- Reset values: ready=1, done=0, Diff=0, Bout=0, Ovf=0. State is IDLE, the counter is 0 and the borrow FF is 0.
- rst has priority over every other input in the same cycle.
- rst during SHIFT aborts the operation. No done pulse is produced and the outputs return to their reset values.
- Latency: start is accepted in cycle 0. SHIFT occupies cycles 1..N. done=1 in cycle N+1.
  - For N=4, done is high in cycle 5.
- Throughput with back-to-back starts: one result every N+1 cycles.
- done is high for exactly one cycle per accepted start.
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SUB_OVERFLOW_EN defined:
  - Port Ovf exists.
  - On entry to DONE, Ovf = (a_{N−1} ^ b_{N−1}) & (a_{N−1} ^ d_{N−1}). This uses the captured operand MSBs and the final difference MSB, and flags two's-complement overflow of A − B − Bin.
  - Ovf is held like Diff.
- SUB_OVERFLOW_EN undefined:
  - Port Ovf and its register are absent.
  - All other behaviour and timing are identical.

## Test plan
- A=9, B=5, Bin=0, start in cycle 0 -> done=1 only in cycle 5, Diff=4, Bout=0. ready=0 in cycles 1–4 and ready=1 in cycle 5.
- A=5, B=9, Bin=0 -> Diff=0xC, Bout=1. Then A=0, B=0, Bin=1 -> Diff=0xF, Bout=1.
- Back-to-back:
  - Hold start=1 with A=0xF, B=0x1 from cycle 0. Change to A=0x3, B=0x3 in cycle 5.
  - Expect done in cycles 5 and 10 with Diff=0xE then Diff=0x0, both with Bout=0.
  - Diff must still read 0xE in cycles 6–9.
- Start while busy: pulse start with A=0xA, B=0x2 in cycle 0. Pulse start again with A=0x1, B=0x7 in cycle 2.
  - Exactly one done, in cycle 5, with Diff=0x8, Bout=0.
- Reset mid-operation: start in cycle 0, rst=1 in cycle 3.
  - No done pulse. Diff=0, Bout=0, ready=1 from cycle 4.
  - A new start in cycle 4 completes normally with done in cycle 9.
- With SUB_OVERFLOW_EN:
  - A=0x8, B=0x1 -> Diff=0x7, Ovf=1, Bout=0.
  - A=0x7, B=0xF -> Diff=0x8, Ovf=1, Bout=1.
  - A=0x3, B=0x1 -> Ovf=0.

Source files
------------

// File: rtl/serial_subtractor_four.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first, through one full-subtractor cell.
// Optional signed-overflow flag Ovf is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor_four #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] Diff,
`ifdef SUB_OVERFLOW_EN
  output logic         Ovf,
`endif
  output logic         Bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_sr, b_sr;
  logic [N-2:0]    res_sr;
  logic [N-1:0]    res_nxt;
  logic            br;
  logic            accept, last_bit, d, br_nxt;

  // A start is honoured in IDLE and DONE alike; SHIFT ignores it.
  assign accept   = start && (state != SHIFT);
  assign last_bit = (cnt == CW'(N - 1));

  // Full-subtractor cell on the current LSBs and the borrow flop.
  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign res_nxt = {d, res_sr};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from the state flops, so no input reaches them.
  always_comb begin
    ready = (state != SHIFT);
    done  = (state == DONE);
  end

  // Datapath: operand shifters, borrow flop, bit counter and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[N-1:1]};
      b_sr   <= {1'b0, b_sr[N-1:1]};
      res_sr <= res_nxt[N-1:1];
      br     <= br_nxt;
      if (!last_bit) cnt <= cnt + CW'(1);
      if (last_bit) begin
        // The last cell sees the operand MSBs, so the overflow test can use them directly.
        Diff <= res_nxt;
        Bout <= br_nxt;
`ifdef SUB_OVERFLOW_EN
        Ovf  <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_four.sv
// Directed self-checking bench for serial_subtractor_four (N=4); Ovf checks apply when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_four;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [N-1:0] a, b, diff;
  logic         ready, done, bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_four #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .ready (ready),
    .done  (done),
    .Diff  (diff),
`ifdef SUB_OVERFLOW_EN
    .Ovf   (ovf),
`endif
    .Bout  (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One complete operation from an idle cycle; returns at the start of a fresh idle cycle.
  task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic tbin, input logic [N-1:0] ed, input logic eb, input logic eo);
    start = 1'b1; a = ta; b = tb_; bin = tbin;
    sample();
    check({tag, " ready c0"}, 32'(ready), 32'd1);
    next_cycle();
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      sample();
      check({tag, " ready busy"}, 32'(ready), 32'd0);
      check({tag, " done busy"}, 32'(done), 32'd0);
      next_cycle();
    end
    sample();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " ready done"}, 32'(ready), 32'd1);
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " bout"}, 32'(bout), 32'(eb));
`ifdef SUB_OVERFLOW_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("%s: unexpected unknown overflow expectation", tag);
`endif
    next_cycle();
    sample();
    check({tag, " done drop"}, 32'(done), 32'd0);
    check({tag, " diff hold"}, 32'(diff), 32'(ed));
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    next_cycle();

    // Basic operations: 9-5, 5-9, 0-0-1, 7-2-1, 0-F-1
    run_op("9-5",   4'h9, 4'h5, 1'b0, 4'h4, 1'b0, 1'b1);
    run_op("5-9",   4'h5, 4'h9, 1'b0, 4'hC, 1'b1, 1'b1);
    run_op("0-0-1", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    run_op("7-2-1", 4'h7, 4'h2, 1'b1, 4'h4, 1'b0, 1'b0);
    run_op("0-F-1", 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 1'b0);

    // Overflow vectors
    run_op("8-1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
    run_op("7-F", 4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
    run_op("3-1", 4'h3, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0);

    // Back-to-back: start held high, operands change in cycle 5
    start = 1'b1; a = 4'hF; b = 4'h1; bin = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      check("b2b done early", 32'(done), 32'd0);
      next_cycle();
    end
    a = 4'h3; b = 4'h3;
    sample();
    check("b2b done c5", 32'(done), 32'd1);
    check("b2b ready c5", 32'(ready), 32'd1);
    check("b2b diff c5", 32'(diff), 32'hE);
    check("b2b bout c5", 32'(bout), 32'd0);
    next_cycle();
    for (int c = 6; c <= 9; c++) begin
      sample();
      check("b2b done mid", 32'(done), 32'd0);
      check("b2b ready mid", 32'(ready), 32'd0);
      check("b2b diff hold", 32'(diff), 32'hE);
      next_cycle();
    end
    start = 1'b0;
    sample();
    check("b2b done c10", 32'(done), 32'd1);
    check("b2b diff c10", 32'(diff), 32'h0);
    check("b2b bout c10", 32'(bout), 32'd0);
    next_cycle();
    sample();
    check("b2b idle done", 32'(done), 32'd0);
    check("b2b idle ready", 32'(ready), 32'd1);
    next_cycle();

    // Start while busy is ignored
    start = 1'b1; a = 4'hA; b = 4'h2; bin = 1'b0;
    next_cycle();
    start = 1'b0;
    next_cycle();
    start = 1'b1; a = 4'h1; b = 4'h7;
    sample();
    check("busy ready c2", 32'(ready), 32'd0);
    next_cycle();
    start = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      sample();
      check("busy done early", 32'(done), 32'd0);
      next_cycle();
    end
    sample();
    check("busy done c5", 32'(done), 32'd1);
    check("busy diff", 32'(diff), 32'h8);
    check("busy bout", 32'(bout), 32'd0);
    next_cycle();
    for (int c = 6; c <= 8; c++) begin
      sample();
      check("busy no second done", 32'(done), 32'd0);
      next_cycle();
    end

    // Reset mid-operation, then a fresh start in cycle 4
    start = 1'b1; a = 4'h9; b = 4'h5; bin = 1'b0;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; start = 1'b1; a = 4'h6; b = 4'h2; bin = 1'b0;
    sample();
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    next_cycle();
    start = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      sample();
      check("restart done early", 32'(done), 32'd0);
      next_cycle();
    end
    sample();
    check("restart done c9", 32'(done), 32'd1);
    check("restart diff", 32'(diff), 32'h4);
    check("restart bout", 32'(bout), 32'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
